// File: rtl/pe_pkg.sv
// Shared PE datapath types: lane-precision encodings and the reduce FSM state.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package pe_pkg;

    // Lane precision of a 32-bit packed posit word.
    localparam int PRECISION_CONFIG_L = 2;

    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd0; // 4 x 8b
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1; // 2 x 16b
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd2; // 1 x 32b

    // Reduction sequencer states.
    typedef enum logic [2:0] {
        RS_IDLE = 3'd0,
        RS_LOAD = 3'd1,
        RS_ACC  = 3'd2,
        RS_EXEC = 3'd3,
        RS_DONE = 3'd4
    } reduce_state_t;

    // Number of posit lanes packed into one word for a given precision.
    // Unknown encodings fall back to a single 32b lane.
    function automatic int lanes_per_word(input logic [PRECISION_CONFIG_L-1:0] mode);
        case (mode)
            PRECISION_CONFIG_8B:  return 4;
            PRECISION_CONFIG_16B: return 2;
            default:              return 1;
        endcase
    endfunction

endpackage

// File: rtl/posit_reduce_sequencer.sv
// Sum/product reduction of a posit word stream through the shared posit_arith_unit.
// Latency: first word 1 cycle, then ARITH_LAT+2 cycles per word; result ARITH_LAT+2 cycles after last accept.
// Backpressure: in_ready only in LOAD/ACC (in_valid low stalls); out_valid held with stable data until out_ready.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   start, cfg_mode/mul/len         reduction request; cfg sampled with start in IDLE only
//   busy                            high whenever not IDLE
//   in_valid/in_ready/in_data       operand word stream (valid/ready)
//   arith_in_0/in_1/mode/mul_en     registered drive of posit_arith_unit (accumulator, operand, cfg)
//   arith_out                       posit_arith_unit result, captured after ARITH_LAT+1 EXEC cycles
//   out_valid/out_ready/out_data    reduction result (valid/ready), out_data is the accumulator
module posit_reduce_sequencer
    import pe_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int ARITH_LAT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [PRECISION_CONFIG_L-1:0] cfg_mode,
    input  logic                          cfg_mul,
    input  logic [LEN_W-1:0]              cfg_len,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_data,
    output logic [31:0]                   arith_in_0,
    output logic [31:0]                   arith_in_1,
    output logic [PRECISION_CONFIG_L-1:0] arith_mode,
    output logic                          arith_mul_en,
    input  logic [31:0]                   arith_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data
);

    // The EXEC wait counter is 2 bits wide, so the arith latency is bounded to 0..3.
    localparam logic [1:0]       LAT_L = 2'(ARITH_LAT);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

    reduce_state_t                 state;
    logic [31:0]                   acc_q;
    logic [31:0]                   op_q;
    logic [LEN_W-1:0]              rem;
    logic [1:0]                    wcnt;
    logic [PRECISION_CONFIG_L-1:0] mode_q;
    logic                          mul_q;

    wire accept = in_valid && in_ready;

    // The arith unit sees only registers, so its inputs never glitch.
    assign arith_in_0   = acc_q;
    assign arith_in_1   = op_q;
    assign arith_mode   = mode_q;
    assign arith_mul_en = mul_q;

    // Result is read straight from the accumulator; acc_q does not move in DONE.
    assign out_data     = acc_q;

    // busy, in_ready and out_valid are registered and updated together with
    // the state transition so they always line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RS_IDLE;
            acc_q     <= '0;
            op_q      <= '0;
            rem       <= '0;
            wcnt      <= '0;
            mode_q    <= '0;
            mul_q     <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                RS_IDLE: begin
                    if (start) begin
                        mode_q <= cfg_mode;
                        mul_q  <= cfg_mul;
                        rem    <= cfg_len;
                        busy   <= 1'b1;
                        if (cfg_len == '0) begin
                            // Empty reduction yields posit zero.
                            acc_q     <= '0;
                            out_valid <= 1'b1;
                            state     <= RS_DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= RS_LOAD;
                        end
                    end
                end

                RS_LOAD: begin
                    // First word seeds the accumulator without an arith operation.
                    if (accept) begin
                        acc_q <= in_data;
                        rem   <= rem - ONE_L;
                        if (rem == ONE_L) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= RS_DONE;
                        end else begin
                            state <= RS_ACC;
                        end
                    end
                end

                RS_ACC: begin
                    if (accept) begin
                        op_q     <= in_data;
                        rem      <= rem - ONE_L;
                        wcnt     <= '0;
                        in_ready <= 1'b0;
                        state    <= RS_EXEC;
                    end
                end

                RS_EXEC: begin
                    // acc_q/op_q are held for ARITH_LAT+1 cycles; the result is
                    // taken on the last one, when the unit's output is settled.
                    if (wcnt == LAT_L) begin
                        acc_q <= arith_out;
                        if (rem == '0) begin
                            out_valid <= 1'b1;
                            state     <= RS_DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= RS_ACC;
                        end
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end

                RS_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= RS_IDLE;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= RS_IDLE;
                end
            endcase
        end
    end

    // Words may only be taken while the FSM is collecting operands.
    a_accept_in_load_acc: assert property (@(posedge clk) disable iff (rst)
        accept |-> (state == RS_LOAD || state == RS_ACC));

endmodule
